// File: rtl/conv_pkg.sv
// Shared state encoding, lane-mask constants and helpers for the
// two-window convolution scheduler and its position walker.
package conv_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_EMIT,
        ST_FINISH
    } conv_state_t;

    localparam logic [1:0] KEEP_BOTH = 2'b11;
    localparam logic [1:0] KEEP_LOW  = 2'b01;

    localparam int KERNEL_SIZE_DEF = 3;
    localparam int MIN_DIM         = KERNEL_SIZE_DEF;

    // Number of valid lanes in a beat; drives the output address step.
    function automatic logic [1:0] keep_count(input logic [1:0] keep);
        return {1'b0, keep[0]} + {1'b0, keep[1]};
    endfunction

endpackage

// File: rtl/conv_pos_walker.sv
// Row/column/address walker over the valid output positions of one job,
// stepping two columns (one window pair) per advance.
module conv_pos_walker
    import conv_pkg::*;
#(
    parameter int DIM_WIDTH      = 6,
    parameter int OUT_ADDR_WIDTH = 12
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      init,
    input  logic                      advance,
    input  logic [DIM_WIDTH-1:0]      ow,
    input  logic [DIM_WIDTH-1:0]      oh,
    output logic [DIM_WIDTH-1:0]      row,
    output logic [DIM_WIDTH-1:0]      col,
    output logic [OUT_ADDR_WIDTH-1:0] addr,
    output logic [1:0]                keep,
    output logic                      last
);

    localparam int CW = DIM_WIDTH + 1;

    logic [DIM_WIDTH-1:0]      row_reg, row_next;
    logic [DIM_WIDTH-1:0]      col_reg, col_next;
    logic [OUT_ADDR_WIDTH-1:0] addr_reg, addr_next;
    logic [CW-1:0]             col_ext, row_ext, ow_ext, oh_ext;
    logic                      row_end;

    // One extra bit so col+2 never wraps near the top of the range.
    assign col_ext = {1'b0, col_reg};
    assign row_ext = {1'b0, row_reg};
    assign ow_ext  = {1'b0, ow};
    assign oh_ext  = {1'b0, oh};

    assign row_end = (col_ext + CW'(2)) >= ow_ext;
    assign keep    = ((col_ext + CW'(1)) < ow_ext) ? KEEP_BOTH : KEEP_LOW;
    assign last    = row_end && ((row_ext + CW'(1)) >= oh_ext);

    always_comb begin
        row_next  = row_reg;
        col_next  = col_reg;
        addr_next = addr_reg;
        if (init) begin
            row_next  = '0;
            col_next  = '0;
            addr_next = '0;
        end else if (advance) begin
            addr_next = addr_reg + OUT_ADDR_WIDTH'(keep_count(keep));
            if (row_end) begin
                col_next = '0;
                row_next = row_reg + DIM_WIDTH'(1);
            end else begin
                col_next = col_reg + DIM_WIDTH'(2);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_reg  <= '0;
            col_reg  <= '0;
            addr_reg <= '0;
        end else begin
            row_reg  <= row_next;
            col_reg  <= col_next;
            addr_reg <= addr_next;
        end
    end

    assign row  = row_reg;
    assign col  = col_reg;
    assign addr = addr_reg;

endmodule

// File: rtl/conv_scheduler.sv
// Job sequencer for the two-window 3x3 convolution engine: issues one start
// per window pair, forwards both results over valid/ready, aborts on watchdog.
module conv_scheduler
    import conv_pkg::*;
#(
    parameter int DATA_WIDTH     = 8,
    parameter int KERNEL_SIZE    = MIN_DIM,
    parameter int DIM_WIDTH      = 6,
    parameter int OUT_ADDR_WIDTH = 12,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic [DIM_WIDTH-1:0]      i_cfg_width,
    input  logic [DIM_WIDTH-1:0]      i_cfg_height,
    input  logic                      i_job_valid,
    output logic                      o_job_ready,
    output logic                      o_conv_start,
    output logic [DIM_WIDTH-1:0]      o_win_row,
    output logic [DIM_WIDTH-1:0]      o_win_col,
    input  logic                      i_conv_done,
    input  logic [DATA_WIDTH-1:0]     i_conv_result1,
    input  logic [DATA_WIDTH-1:0]     i_conv_result2,
    output logic                      o_out_valid,
    input  logic                      i_out_ready,
    output logic [2*DATA_WIDTH-1:0]   o_out_data,
    output logic [1:0]                o_out_keep,
    output logic [OUT_ADDR_WIDTH-1:0] o_out_addr,
    output logic                      o_busy,
    output logic                      o_done,
    output logic                      o_error
);

    localparam int                    WD_WIDTH = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [DIM_WIDTH:0]    MIN_EXT  = (DIM_WIDTH + 1)'(KERNEL_SIZE);
    localparam logic [DIM_WIDTH-1:0]  SHRINK   = DIM_WIDTH'(KERNEL_SIZE - 1);
    localparam logic [WD_WIDTH-1:0]   WD_LAST  = WD_WIDTH'(TIMEOUT_CYCLES - 1);

    conv_state_t               state_reg, state_next;
    logic [DIM_WIDTH-1:0]      width_reg, height_reg;
    logic [WD_WIDTH-1:0]       wdog_reg;
    logic                      error_reg;
    logic                      armed_reg;
    logic [2*DATA_WIDTH-1:0]   lane_in, lane_bus;
    logic                      accept, cfg_bad, timeout, handshake, capture;
    logic [DIM_WIDTH-1:0]      ow, oh, row, col;
    logic [OUT_ADDR_WIDTH-1:0] addr;
    logic [1:0]                keep;
    logic                      last;

    // armed_reg keeps o_job_ready low while reset is held and for no longer.
    assign accept    = (state_reg == ST_IDLE) && armed_reg && i_job_valid;
    assign cfg_bad   = ({1'b0, i_cfg_width} < MIN_EXT) || ({1'b0, i_cfg_height} < MIN_EXT);
    assign timeout   = (wdog_reg == WD_LAST);
    assign handshake = (state_reg == ST_EMIT) && i_out_ready;
    assign capture   = (state_reg == ST_WAIT) && i_conv_done;
    assign ow        = width_reg - SHRINK;
    assign oh        = height_reg - SHRINK;
    assign lane_in   = {i_conv_result2, i_conv_result1};

    conv_pos_walker #(
        .DIM_WIDTH      (DIM_WIDTH),
        .OUT_ADDR_WIDTH (OUT_ADDR_WIDTH)
    ) u_walker (
        .clk     (i_clk),
        .rst_n   (i_rst_n),
        .init    (accept),
        .advance (handshake),
        .ow      (ow),
        .oh      (oh),
        .row     (row),
        .col     (col),
        .addr    (addr),
        .keep    (keep),
        .last    (last)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:   if (accept) state_next = cfg_bad ? ST_FINISH : ST_ISSUE;
            ST_ISSUE:  state_next = ST_WAIT;
            // done has priority over a watchdog expiry in the same cycle
            ST_WAIT:   if (i_conv_done) state_next = ST_EMIT;
                       else if (timeout) state_next = ST_FINISH;
            ST_EMIT:   if (i_out_ready) state_next = last ? ST_FINISH : ST_ISSUE;
            ST_FINISH: state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        o_job_ready  = 1'b0;
        o_conv_start = 1'b0;
        o_out_valid  = 1'b0;
        o_out_keep   = '0;
        o_done       = 1'b0;
        o_busy       = (state_reg != ST_IDLE);
        case (state_reg)
            ST_IDLE:   o_job_ready = armed_reg;
            ST_ISSUE:  o_conv_start = 1'b1;
            ST_EMIT: begin
                o_out_valid = 1'b1;
                o_out_keep  = keep;
            end
            ST_FINISH: o_done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            armed_reg  <= 1'b0;
            width_reg  <= '0;
            height_reg <= '0;
            wdog_reg   <= '0;
            error_reg  <= 1'b0;
        end else begin
            armed_reg <= 1'b1;
            if (accept) begin
                width_reg  <= i_cfg_width;
                height_reg <= i_cfg_height;
                error_reg  <= cfg_bad;
            end else if ((state_reg == ST_WAIT) && !i_conv_done && timeout) begin
                error_reg <= 1'b1;
            end
            if (state_reg == ST_WAIT) begin
                wdog_reg <= wdog_reg + WD_WIDTH'(1);
            end else begin
                wdog_reg <= '0;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_lane
            logic [DATA_WIDTH-1:0] lane_reg;
            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    lane_reg <= '0;
                end else if (capture) begin
                    lane_reg <= lane_in[gi*DATA_WIDTH +: DATA_WIDTH];
                end
            end
            assign lane_bus[gi*DATA_WIDTH +: DATA_WIDTH] = lane_reg;
        end
    endgenerate

    assign o_win_row  = row;
    assign o_win_col  = col;
    assign o_out_addr = addr;
    assign o_out_data = lane_bus;
    assign o_error    = error_reg;

endmodule

// File: tb/tb_conv_scheduler.sv
// Randomized bench for conv_scheduler; expected windows, masks and addresses
// come from a plain loop over the output image.
module tb_conv_scheduler;

    localparam int DW   = 8;
    localparam int KS   = 3;
    localparam int DIMW = 6;
    localparam int AW   = 12;
    localparam int TO   = 64;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [DIMW-1:0]   i_cfg_width, i_cfg_height;
    logic              i_job_valid, i_conv_done, i_out_ready;
    logic [DW-1:0]     i_conv_result1, i_conv_result2;
    logic              o_job_ready, o_conv_start, o_out_valid, o_busy, o_done, o_error;
    logic [DIMW-1:0]   o_win_row, o_win_col;
    logic [2*DW-1:0]   o_out_data;
    logic [1:0]        o_out_keep;
    logic [AW-1:0]     o_out_addr;

    int cyc = 0;
    int n_checks = 0;
    int n_pass = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    conv_scheduler #(
        .DATA_WIDTH     (DW),
        .KERNEL_SIZE    (KS),
        .DIM_WIDTH      (DIMW),
        .OUT_ADDR_WIDTH (AW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_cfg_width    (i_cfg_width),
        .i_cfg_height   (i_cfg_height),
        .i_job_valid    (i_job_valid),
        .o_job_ready    (o_job_ready),
        .o_conv_start   (o_conv_start),
        .o_win_row      (o_win_row),
        .o_win_col      (o_win_col),
        .i_conv_done    (i_conv_done),
        .i_conv_result1 (i_conv_result1),
        .i_conv_result2 (i_conv_result2),
        .o_out_valid    (o_out_valid),
        .i_out_ready    (i_out_ready),
        .o_out_data     (o_out_data),
        .o_out_keep     (o_out_keep),
        .o_out_addr     (o_out_addr),
        .o_busy         (o_busy),
        .o_done         (o_done),
        .o_error        (o_error)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    function automatic logic [63:0] all_outs();
        return 64'({o_job_ready, o_conv_start, o_win_row, o_win_col, o_out_valid, o_out_data,
                    o_out_keep, o_out_addr, o_busy, o_done, o_error});
    endfunction

    // hang: engine never answers; stall: cycles of ready-low on the first beat;
    // abort: reset during WAIT of the second pair.
    task automatic run_job(input int w, input int h, input bit hang, input int stall,
                           input bit abort, input bit rdy_rand);
        int ow = w - (KS - 1);
        int oh = h - (KS - 1);
        bit bad = (w < KS) || (h < KS);
        int er[$];
        int ec[$];
        int ea[$];
        int ek[$];
        int acc, next_start, start_cyc, done_at, done_cyc, last_hs, starts, beat, stall_left, t;
        bit prev_valid, finished, aborted, drv_done, drv_ready;
        logic [DW-1:0]   r1, r2;
        logic [2*DW-1:0] exp_data;

        if (!bad) begin
            for (int r = 0; r < oh; r++) begin
                for (int c = 0; c < ow; c += 2) begin
                    er.push_back(r);
                    ec.push_back(c);
                    ea.push_back(r * ow + c);
                    ek.push_back((c + 1 < ow) ? 3 : 1);
                end
            end
        end

        t = 0;
        while (!o_job_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("job_ready_before_accept", o_job_ready, 1);
        i_cfg_width  = DIMW'(w);
        i_cfg_height = DIMW'(h);
        i_job_valid  = 1'b1;
        acc = cyc;
        @(negedge clk);
        i_job_valid  = 1'b0;
        i_cfg_width  = DIMW'($urandom);
        i_cfg_height = DIMW'($urandom);

        next_start = acc + 1;
        start_cyc  = -1;
        done_at    = -1;
        done_cyc   = -1;
        last_hs    = -1;
        starts     = 0;
        beat       = 0;
        stall_left = stall;
        prev_valid = 1'b0;
        finished   = 1'b0;
        aborted    = 1'b0;
        r1 = '0;
        r2 = '0;
        exp_data = '0;

        for (int k = 0; k < 2000 && !finished; k++) begin
            if (k == 0) begin
                check("busy_after_accept", o_busy, 1);
                check("error_after_accept", o_error, bad);
            end
            if (abort && starts == 2 && cyc == start_cyc + 1) begin
                rst_n = 1'b0;
                #1;
                check("outs_in_mid_reset", all_outs(), 0);
                @(negedge clk);
                check("outs_hold_reset", all_outs(), 0);
                i_conv_done = 1'b0;
                i_out_ready = 1'b0;
                rst_n = 1'b1;
                @(negedge clk);
                check("ready_after_mid_reset", o_job_ready, 1);
                aborted = 1'b1;
                break;
            end
            drv_done  = 1'b0;
            drv_ready = 1'b0;
            if (o_conv_start) begin
                check("start_cycle", cyc, next_start);
                if (beat < er.size()) begin
                    check("win_row", o_win_row, er[beat]);
                    check("win_col", o_win_col, ec[beat]);
                end else begin
                    check("unexpected_start", o_conv_start, 0);
                end
                starts++;
                start_cyc = cyc;
                if (!hang) done_at = cyc + 1 + $urandom_range(0, 5);
                r1 = DW'($urandom);
                r2 = DW'($urandom);
            end
            if (done_at == cyc) begin
                drv_done = 1'b1;
                done_cyc = cyc;
                exp_data = {r2, r1};
                i_conv_result1 = r1;
                i_conv_result2 = r2;
            end
            if (o_out_valid && beat < er.size()) begin
                if (!prev_valid) check("valid_latency", cyc, done_cyc + 1);
                check("out_data", o_out_data, exp_data);
                check("out_keep", o_out_keep, ek[beat]);
                check("out_addr", o_out_addr, ea[beat]);
                check("win_hold", {o_win_row, o_win_col}, {DIMW'(er[beat]), DIMW'(ec[beat])});
                if (stall_left > 0) begin
                    stall_left--;
                    drv_done = 1'b1;
                    i_conv_result1 = DW'($urandom);
                    i_conv_result2 = DW'($urandom);
                end else if (!rdy_rand || $urandom_range(0, 3) != 0) begin
                    drv_ready  = 1'b1;
                    last_hs    = cyc;
                    next_start = cyc + 1;
                    beat++;
                end
            end else if (o_out_valid) begin
                check("unexpected_valid", o_out_valid, 0);
            end
            prev_valid = o_out_valid;
            if (o_done) begin
                if (bad)       check("done_cycle", cyc, acc + 1);
                else if (hang) check("done_cycle", cyc, start_cyc + 1 + TO);
                else           check("done_cycle", cyc, last_hs + 1);
                check("error_at_done", o_error, bad || hang);
                check("beat_count", beat, (bad || hang) ? 0 : er.size());
                check("start_count", starts, bad ? 0 : (hang ? 1 : er.size()));
                finished = 1'b1;
            end
            i_conv_done = drv_done;
            i_out_ready = drv_ready;
            @(negedge clk);
        end

        i_conv_done = 1'b0;
        i_out_ready = 1'b0;
        if (!aborted) begin
            if (!finished) check("job_completed_in_budget", finished, 1);
            check("done_one_cycle", o_done, 0);
            check("busy_after_done", o_busy, 0);
            check("ready_after_done", o_job_ready, 1);
            check("error_sticky", o_error, bad || hang);
        end
        $display("job w=%0d h=%0d starts=%0d beats=%0d of %0d err=%0b aborted=%0b",
                 w, h, starts, beat, er.size(), o_error, aborted);
    endtask

    initial begin
        i_cfg_width    = '0;
        i_cfg_height   = '0;
        i_job_valid    = 1'b0;
        i_conv_done    = 1'b0;
        i_out_ready    = 1'b0;
        i_conv_result1 = '0;
        i_conv_result2 = '0;
        rst_n          = 1'b0;
        repeat (3) @(negedge clk);
        check("outs_in_reset", all_outs(), 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_release", o_job_ready, 1);

        run_job(4, 4, 1'b0, 0, 1'b0, 1'b0);
        run_job(5, 3, 1'b0, 0, 1'b0, 1'b0);
        run_job(6, 4, 1'b0, 5, 1'b0, 1'b1);
        run_job(4, 4, 1'b1, 0, 1'b0, 1'b0);
        run_job(4, 4, 1'b0, 0, 1'b0, 1'b1);
        run_job(2, 8, 1'b0, 0, 1'b0, 1'b0);
        run_job(4, 4, 1'b0, 0, 1'b1, 1'b0);
        run_job(4, 4, 1'b0, 0, 1'b0, 1'b0);
        for (int j = 0; j < 10; j++) begin
            run_job($urandom_range(2, 12), $urandom_range(2, 7), 1'b0,
                    $urandom_range(0, 3), 1'b0, 1'b1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
